// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and its users: opcode encodings and
// the NOP/bubble instruction word.
package fetch_stage_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDI = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_LW   = 4'h5,
        OP_SW   = 4'h6,
        OP_BEQ  = 4'h7,
        OP_J    = 4'h8,
        OP_JAL  = 4'h9,
        OP_JR   = 4'hA
    } opcode_e;

    // All-zero word decodes as ADD R0,R0,R0, so a bubble is architecturally inert.
    localparam logic [15:0] INST_NOP = 16'h0000;

    function automatic opcode_e inst_opcode(input logic [15:0] inst);
        return opcode_e'(inst[15:12]);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_if #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
);
    logic              stall;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;
    logic              jump;
    logic [PC_W-1:0]   jump_target;
    logic              jr;
    logic [PC_W-1:0]   jr_target;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_data;
    logic [INST_W-1:0] ifid_inst;
    logic [PC_W-1:0]   ifid_pc1;
    logic              ifid_valid;
    logic              redirect;

    modport master (
        input  stall, br_taken, br_target, jump, jump_target, jr, jr_target, imem_data,
        output imem_addr, ifid_inst, ifid_pc1, ifid_valid, redirect
    );

    modport slave (
        output stall, br_taken, br_target, jump, jump_target, jr, jr_target, imem_data,
        input  imem_addr, ifid_inst, ifid_pc1, ifid_valid, redirect
    );
endinterface

// File: rtl/fetch_stage_pc_next_sel.sv
// Combinational next-PC priority selector: rst, jr, jump, branch, stall, PC+1.
module pc_next_sel #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            rst,
    input  logic [PC_W-1:0] pc,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    output logic [PC_W-1:0] pc_plus1,
    output logic [PC_W-1:0] next_pc,
    output logic            redirect
);
    // Plain PC_W-bit add: all-ones wraps to zero with no carry kept.
    assign pc_plus1 = pc + PC_W'(1);
    assign redirect = jr | jump | br_taken;

    always_comb begin
        next_pc = pc_plus1;
        if (rst)
            next_pc = RESET_PC;
        else if (jr)
            next_pc = jr_target;
        else if (jump)
            next_pc = jump_target;
        else if (br_taken)
            next_pc = br_target;
        else if (stall)
            next_pc = pc;
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and the IF/ID pipeline
// register with stall hold and redirect squash.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    logic [PC_W-1:0]   pc_p0;
    logic [PC_W-1:0]   pc_plus1;
    logic [PC_W-1:0]   next_pc;
    logic              redirect;
    logic [INST_W-1:0] inst_p1;
    logic [PC_W-1:0]   pc1_p1;
    logic              vld_p1;

    pc_next_sel #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_next_sel (
        .rst         (rst),
        .pc          (pc_p0),
        .stall       (bus.stall),
        .br_taken    (bus.br_taken),
        .br_target   (bus.br_target),
        .jump        (bus.jump),
        .jump_target (bus.jump_target),
        .jr          (bus.jr),
        .jr_target   (bus.jr_target),
        .pc_plus1    (pc_plus1),
        .next_pc     (next_pc),
        .redirect    (redirect)
    );

    // p0: PC register, drives the instruction memory address directly
    always_ff @(posedge clk) begin
        pc_p0 <= next_pc;
    end

    // p1: IF/ID register; a redirect squashes the wrong-path fetch even under stall
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_p1 <= '0;
            pc1_p1  <= '0;
            vld_p1  <= 1'b0;
        end else if (redirect) begin
            inst_p1 <= INST_W'(INST_NOP);
            pc1_p1  <= '0;
            vld_p1  <= 1'b0;
        end else if (!bus.stall) begin
            inst_p1 <= bus.imem_data;
            pc1_p1  <= pc_plus1;
            vld_p1  <= 1'b1;
        end
    end

    assign bus.imem_addr  = pc_p0;
    assign bus.ifid_inst  = inst_p1;
    assign bus.ifid_pc1   = pc1_p1;
    assign bus.ifid_valid = vld_p1;
    assign bus.redirect   = redirect;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed control vectors push expected
// post-edge state; a negedge monitor pops and compares.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int          PC_W     = 8;
    localparam int          INST_W   = 16;
    localparam logic [7:0]  RESET_PC = 8'h00;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] inst;
        logic [7:0]  pc1;
        logic        vld;
        int          id;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   vec_id;

    fetch_stage_if #(.PC_W(PC_W), .INST_W(INST_W)) bus_if ();

    fetch_stage #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Instruction memory: word at address A is 16'h1000 + A (ADDI opcode).
    assign bus_if.imem_data = {OP_ADDI, 4'h0, bus_if.imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int id, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d: got %h, expected %h", nm, id, act, req);
        end
    endtask

    task automatic step(input logic r, input logic s,
                        input logic b, input logic [7:0] bt,
                        input logic j, input logic [7:0] jt,
                        input logic jrv, input logic [7:0] jrt,
                        input logic [7:0] epc, input logic [15:0] einst,
                        input logic [7:0] epc1, input logic ev);
        exp_t e;
        rst                = r;
        bus_if.stall       = s;
        bus_if.br_taken    = b;
        bus_if.br_target   = bt;
        bus_if.jump        = j;
        bus_if.jump_target = jt;
        bus_if.jr          = jrv;
        bus_if.jr_target   = jrt;
        #1;
        check("redirect", vec_id, 32'(bus_if.redirect), 32'(b | j | jrv));
        @(posedge clk);
        e.pc   = epc;
        e.inst = einst;
        e.pc1  = epc1;
        e.vld  = ev;
        e.id   = vec_id;
        exp_q.push_back(e);
        vec_id++;
        #1;
    endtask

    // Monitor: compare the post-edge state once per queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("imem_addr",  e.id, 32'(bus_if.imem_addr),  32'(e.pc));
                check("ifid_inst",  e.id, 32'(bus_if.ifid_inst),  32'(e.inst));
                check("ifid_pc1",   e.id, 32'(bus_if.ifid_pc1),   32'(e.pc1));
                check("ifid_valid", e.id, 32'(bus_if.ifid_valid), 32'(e.vld));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d expectations pending",
                 exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        vec_id = 0;
        //    rst stall br  bt     jmp jt     jr  jrt    | pc     inst      pc1    vld
        // Reset
        step(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   RESET_PC, INST_NOP, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   RESET_PC, INST_NOP, 8'h00, 0);
        // Sequential run
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h01, 16'h1000, 8'h01, 1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h02, 16'h1001, 8'h02, 1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h03, 16'h1002, 8'h03, 1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h04, 16'h1003, 8'h04, 1);
        // Stall at PC=4 for three cycles, then resume
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h04, 16'h1003, 8'h04, 1);
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h04, 16'h1003, 8'h04, 1);
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h04, 16'h1003, 8'h04, 1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h05, 16'h1004, 8'h05, 1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h06, 16'h1005, 8'h06, 1);
        // Taken branch at PC=6 to 0x20
        step(0, 0, 1, 8'h20, 0, 8'h00, 0, 8'h00,   8'h20, INST_NOP, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h21, 16'h1020, 8'h21, 1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h22, 16'h1021, 8'h22, 1);
        // All redirects plus stall: jr wins and bubble inserted
        step(0, 1, 1, 8'h20, 1, 8'h30, 1, 8'h40,   8'h40, INST_NOP, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h41, 16'h1040, 8'h41, 1);
        // Jump beats branch
        step(0, 0, 1, 8'h20, 1, 8'h30, 0, 8'h00,   8'h30, INST_NOP, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h31, 16'h1030, 8'h31, 1);
        // jr alone to 0xFF, then wrap to 0
        step(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hFF,   8'hFF, INST_NOP, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h00, 16'h10FF, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h01, 16'h1000, 8'h01, 1);
        // Reset in the middle of a stall with a jump pending
        step(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h01, 16'h1000, 8'h01, 1);
        step(1, 1, 0, 8'h00, 1, 8'h30, 0, 8'h00,   RESET_PC, INST_NOP, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h01, 16'h1000, 8'h01, 1);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00,   8'h02, 16'h1001, 8'h02, 1);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", -1, 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have these parameters: PC_W, default 8, program-counter width in instruction words.
REQ-002 The block SHALL have these parameters: INST_W, default 16, instruction width.
REQ-003 The block SHALL have these parameters: RESET_PC, default 0, PC value loaded on reset.
REQ-004 The block SHALL have these ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID register (hazard from decode).
- br_taken  input  1  BEQ resolved taken in execute.
- br_target  input  PC_W  branch destination.
- jump  input  1  J/JAL resolved.
- jump_target  input  PC_W  jump destination.
- jr  input  1  JR resolved.
- jr_target  input  PC_W  register-held return address.
- imem_addr  output  PC_W  instruction memory address, equal to the current PC.
- imem_data  input  INST_W  combinational instruction memory read data.
- ifid_inst  output  INST_W  registered instruction to decode/control; opcode is ifid_inst[15:12].
- ifid_pc1  output  PC_W  registered PC+1 of that instruction (JAL link value).
- ifid_valid  output  1  ifid_inst holds a real fetched instruction.
- redirect  output  1  combinational: a redirect is being taken this cycle.

Function
REQ-005 PC SHALL be a PC_W-bit register; imem_addr SHALL equal PC combinationally.
REQ-006 Next-PC priority, highest first, SHALL be: rst -> RESET_PC; jr -> jr_target; jump -> jump_target; br_taken -> br_target; stall -> PC; else PC+1.
REQ-007 PC+1 SHALL wrap modulo 2^PC_W (all-ones PC -> 0), with no flag raised.
REQ-008 redirect SHALL be the OR of jr, jump and br_taken.
REQ-009 A redirect SHALL override stall for both the PC and the IF/ID register.
REQ-010 When a redirect occurs, IF/ID SHALL load a bubble on the same edge: ifid_inst = 0, ifid_valid = 0, and ifid_pc1 = 0.
REQ-011 When stall is high and there is no redirect, ifid_inst, ifid_pc1 and ifid_valid SHALL hold their values.
REQ-012 Otherwise, IF/ID SHALL load imem_data, PC+1 (wrapped) and 1 on the edge.
REQ-013 Fetch-to-decode latency SHALL be one cycle: the instruction at PC N appears on ifid_inst the cycle after PC = N.
REQ-014 A redirect target SHALL be fetched in the cycle after the redirect, and SHALL appear on ifid_inst one cycle after that (two-cycle redirect penalty). The wrong-path instruction SHALL be squashed by REQ-010.
REQ-015 Multiple simultaneous redirect inputs SHALL resolve per REQ-006, with no error indication.
REQ-016 A bubble SHALL decode as ADD R0,R0,R0; the downstream stage SHALL gate write-enable with ifid_valid.

Reset
REQ-017 On rst at a rising edge the block SHALL set PC = RESET_PC, ifid_inst = 0, ifid_pc1 = 0 and ifid_valid = 0, regardless of stall or redirect inputs.
REQ-018 An rst asserted in the middle of a stall or redirect SHALL discard it. The first fetch after reset SHALL occur at RESET_PC in the first cycle with rst low.
REQ-019 The block SHALL use no asynchronous reset paths.

Structure
REQ-020 The opcode constants used by the bench for instruction encoding SHALL come from the shared define include, not be local. The NOP encoding constant (16'h0000) SHALL be added to that include.
REQ-021 The next-PC mux SHALL be one natural sub-module, pc_next_sel: a combinational priority selector, instantiated once. All state SHALL live in fetch_stage.

Verification
REQ-022 Sequential run: reset, then 5 cycles with no controls, imem returning 16'h1000+addr -> ifid_inst = 1000, 1001, 1002, 1003 on successive cycles, and ifid_pc1 = 1, 2, 3, 4.
REQ-023 Stall: stall high for 3 cycles while PC = 4 -> PC holds at 4 and ifid_inst holds 16'h1003 for 3 cycles, then resumes with 1004.
REQ-024 Taken branch: br_taken = 1 with br_target = 8'h20 at PC = 6 -> next cycle ifid_valid = 0 and PC = 20; the following cycle ifid_inst = 16'h1020.
REQ-025 Priority and override: jr = 1 (target 8'h40), jump = 1 (8'h30), br_taken = 1 (8'h20) and stall = 1 together -> PC = 40 and a bubble is inserted.
REQ-026 Wrap: PC = 8'hFF with no controls -> next PC = 0 and ifid_pc1 = 0.
REQ-027 Reset mid-stall: stall = 1 and jump = 1 with rst = 1 -> PC = RESET_PC and ifid_valid = 0. After rst falls with stall = 0, the first valid instruction is from RESET_PC.
